// File: rtl/omr_sheet_loader_if.sv
// Bubble-read and sheet-handoff bundle between the scanner/grader (master) and the
// sheet loader (slave).
interface omr_sheet_loader_if #(
   parameter int unsigned NUM_Q = 10,
   parameter int unsigned OPT_W = 4
);
   localparam int unsigned ANS_W = NUM_Q * OPT_W;
   localparam int unsigned CNT_W = $clog2(NUM_Q + 1);
   localparam int unsigned IDX_W = $clog2(NUM_Q);

   logic             sheet_start;
   logic             bubble_valid;
   logic [OPT_W-1:0] bubble_data;
   logic             bubble_ready;
   logic [ANS_W-1:0] student_answers;
   logic             sheet_valid;
   logic             sheet_ack;
   logic [NUM_Q-1:0] invalid_mask;
   logic [CNT_W-1:0] invalid_cnt;
   logic [IDX_W-1:0] q_index;

   modport master (
      output sheet_start, bubble_valid, bubble_data, sheet_ack,
      input  bubble_ready, student_answers, sheet_valid, invalid_mask, invalid_cnt, q_index
   );

   modport slave (
      input  sheet_start, bubble_valid, bubble_data, sheet_ack,
      output bubble_ready, student_answers, sheet_valid, invalid_mask, invalid_cnt, q_index
   );
endinterface

// File: rtl/omr_sheet_loader.sv
// Assembles one answer sheet from per-question bubble reads and holds it for the grader.
// Optional OMR_INVALID_BLANK_EN: non-one-hot reads are stored as an all-zero nibble.
module omr_sheet_loader #(
   parameter int unsigned NUM_Q = 10,
   parameter int unsigned OPT_W = 4
) (
   input logic               clk,
   input logic               reset_n,
   omr_sheet_loader_if.slave bus
);
   localparam int unsigned ANS_W = NUM_Q * OPT_W;
   localparam int unsigned CNT_W = $clog2(NUM_Q + 1);
   localparam int unsigned IDX_W = $clog2(NUM_Q);

   typedef enum logic [1:0] {StIdle, StLoad, StHold} state_e;

   state_e           state_q, state_d;
   logic [ANS_W-1:0] answers_q, answers_d;
   logic [NUM_Q-1:0] mask_q, mask_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [IDX_W-1:0] idx_q, idx_d;

   logic             nib_onehot;
   logic [OPT_W-1:0] nib_store;
   logic             start_clr;
   logic             xfer;
   logic             last_q;
   logic             bubble_ready;
   logic             sheet_valid;

   always_comb begin
      nib_onehot = (bus.bubble_data != '0) &&
                   ((bus.bubble_data & (bus.bubble_data - OPT_W'(1))) == '0);
`ifdef OMR_INVALID_BLANK_EN
      nib_store  = nib_onehot ? bus.bubble_data : '0;
`else
      nib_store  = bus.bubble_data;
`endif
      // A start in HOLD waits for the ack; a start in LOAD wins over a same-cycle read.
      start_clr  = bus.sheet_start && (state_q != StHold);
      xfer       = (state_q == StLoad) && bus.bubble_valid && !bus.sheet_start;
      last_q     = (idx_q == IDX_W'(NUM_Q - 1));
   end

   // FSM state register
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state_q <= StIdle;
      else          state_q <= state_d;
   end

   // FSM next state
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle:  if (bus.sheet_start) state_d = StLoad;
         StLoad:  if (xfer && last_q)  state_d = StHold;
         StHold:  if (bus.sheet_ack)   state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   // FSM outputs
   always_comb begin
      bubble_ready = (state_q == StLoad);
      sheet_valid  = (state_q == StHold);
   end

   always_comb begin
      answers_d = answers_q;
      mask_d    = mask_q;
      cnt_d     = cnt_q;
      idx_d     = idx_q;
      if (start_clr) begin
         answers_d = '0;
         mask_d    = '0;
         cnt_d     = '0;
         idx_d     = '0;
      end else if (xfer) begin
         // Question 0 occupies the most significant nibble.
         for (int k = 0; k < NUM_Q; k++) begin
            if (idx_q == IDX_W'(k)) begin
               answers_d[(NUM_Q - 1 - k) * OPT_W +: OPT_W] = nib_store;
               if (!nib_onehot) mask_d[k] = 1'b1;
            end
         end
         if (!nib_onehot) cnt_d = cnt_q + CNT_W'(1);
         if (!last_q)     idx_d = idx_q + IDX_W'(1);
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         answers_q <= '0;
         mask_q    <= '0;
         cnt_q     <= '0;
         idx_q     <= '0;
      end else begin
         answers_q <= answers_d;
         mask_q    <= mask_d;
         cnt_q     <= cnt_d;
         idx_q     <= idx_d;
      end
   end

   assign bus.bubble_ready    = bubble_ready;
   assign bus.sheet_valid     = sheet_valid;
   assign bus.student_answers = answers_q;
   assign bus.invalid_mask    = mask_q;
   assign bus.invalid_cnt     = cnt_q;
   assign bus.q_index         = idx_q;
endmodule

// File: tb/tb_omr_sheet_loader.sv
// Directed bench for omr_sheet_loader; expected sheets are hand-packed hex constants.
module tb_omr_sheet_loader;
   logic clk;
   logic reset_n;
   int   n_checks;
   int   n_errors;

   omr_sheet_loader_if #(.NUM_Q(10), .OPT_W(4)) bus ();

   omr_sheet_loader #(.NUM_Q(10), .OPT_W(4)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic start_sheet();
      bus.sheet_start = 1'b1;
      tick();
      bus.sheet_start = 1'b0;
   endtask

   task automatic send(input logic [3:0] nib);
      bus.bubble_valid = 1'b1;
      bus.bubble_data  = nib;
      tick();
      bus.bubble_valid = 1'b0;
   endtask

   task automatic send_sheet(input logic [39:0] v);
      for (int k = 0; k < 10; k++) send(v[(9 - k) * 4 +: 4]);
   endtask

   logic [39:0] sheet_a;
   logic [39:0] sheet_b;
   logic [39:0] sheet_c;
   logic [39:0] sheet_d;
   logic [39:0] exp_b;
   int          valid_seen;

   initial begin
      n_checks = 0;
      n_errors = 0;
      sheet_a  = 40'h1224441888;
      sheet_b  = 40'h1224541880;
      sheet_c  = 40'h8421842184;
      sheet_d  = 40'h1248124812;
`ifdef OMR_INVALID_BLANK_EN
      exp_b    = 40'h1224041880;
`else
      exp_b    = 40'h1224541880;
`endif
      bus.sheet_start  = 1'b0;
      bus.bubble_valid = 1'b0;
      bus.bubble_data  = 4'h0;
      bus.sheet_ack    = 1'b0;
      reset_n          = 1'b0;
      #12;
      check_eq("rst_answers", 64'(bus.student_answers), 64'h0);
      check_eq("rst_mask", 64'(bus.invalid_mask), 64'h0);
      check_eq("rst_cnt", 64'(bus.invalid_cnt), 64'h0);
      check_eq("rst_idx", 64'(bus.q_index), 64'h0);
      check_eq("rst_valid", 64'(bus.sheet_valid), 64'h0);
      check_eq("rst_ready", 64'(bus.bubble_ready), 64'h0);
      reset_n = 1'b1;
      tick();

      // Reads and acks while idle are ignored
      send(4'h1);
      bus.sheet_ack = 1'b1;
      tick();
      bus.sheet_ack = 1'b0;
      check_eq("idle_idx", 64'(bus.q_index), 64'h0);
      check_eq("idle_answers", 64'(bus.student_answers), 64'h0);
      check_eq("idle_ready", 64'(bus.bubble_ready), 64'h0);

      // Clean sheet
      start_sheet();
      check_eq("load_ready", 64'(bus.bubble_ready), 64'h1);
      bus.sheet_ack = 1'b1;
      tick();
      bus.sheet_ack = 1'b0;
      check_eq("load_ack_ignored", 64'(bus.bubble_ready), 64'h1);
      for (int k = 0; k < 9; k++) send(sheet_a[(9 - k) * 4 +: 4]);
      check_eq("a_idx9", 64'(bus.q_index), 64'h9);
      check_eq("a_valid_early", 64'(bus.sheet_valid), 64'h0);
      send(sheet_a[3:0]);
      check_eq("a_valid", 64'(bus.sheet_valid), 64'h1);
      check_eq("a_answers", 64'(bus.student_answers), 64'h1224441888);
      check_eq("a_cnt", 64'(bus.invalid_cnt), 64'h0);
      check_eq("a_idx_sat", 64'(bus.q_index), 64'h9);
      check_eq("a_ready_hold", 64'(bus.bubble_ready), 64'h0);

      // HOLD ignores reads and starts, then ack
      bus.bubble_valid = 1'b1;
      bus.bubble_data  = 4'hF;
      bus.sheet_start  = 1'b1;
      repeat (3) tick();
      bus.bubble_valid = 1'b0;
      bus.sheet_start  = 1'b0;
      check_eq("hold_answers", 64'(bus.student_answers), 64'h1224441888);
      check_eq("hold_valid", 64'(bus.sheet_valid), 64'h1);
      check_eq("hold_mask", 64'(bus.invalid_mask), 64'h0);
      bus.sheet_ack = 1'b1;
      tick();
      bus.sheet_ack = 1'b0;
      check_eq("ack_valid", 64'(bus.sheet_valid), 64'h0);
      check_eq("ack_ready", 64'(bus.bubble_ready), 64'h0);
      check_eq("ack_retain", 64'(bus.student_answers), 64'h1224441888);

      // Invalid reads: q4 = 0101, q9 = 0000
      start_sheet();
      check_eq("start_clear", 64'(bus.student_answers), 64'h0);
      send_sheet(sheet_b);
      check_eq("b_mask", 64'(bus.invalid_mask), 64'h210);
      check_eq("b_cnt", 64'(bus.invalid_cnt), 64'h2);
      check_eq("b_answers", 64'(bus.student_answers), 64'(exp_b));

      // Ack and start together in HOLD: ack only
      bus.sheet_ack   = 1'b1;
      bus.sheet_start = 1'b1;
      tick();
      bus.sheet_ack   = 1'b0;
      bus.sheet_start = 1'b0;
      check_eq("ackstart_valid", 64'(bus.sheet_valid), 64'h0);
      check_eq("ackstart_ready", 64'(bus.bubble_ready), 64'h0);
      tick();
      check_eq("ackstart_idle", 64'(bus.bubble_ready), 64'h0);

      // Abort after five reads, with a read in the abort cycle
      start_sheet();
      for (int k = 0; k < 5; k++) send(4'hF);
      check_eq("part_idx", 64'(bus.q_index), 64'h5);
      bus.sheet_start  = 1'b1;
      bus.bubble_valid = 1'b1;
      bus.bubble_data  = 4'h1;
      tick();
      bus.sheet_start  = 1'b0;
      bus.bubble_valid = 1'b0;
      check_eq("abort_idx", 64'(bus.q_index), 64'h0);
      check_eq("abort_answers", 64'(bus.student_answers), 64'h0);
      check_eq("abort_mask", 64'(bus.invalid_mask), 64'h0);
      check_eq("abort_cnt", 64'(bus.invalid_cnt), 64'h0);
      check_eq("abort_ready", 64'(bus.bubble_ready), 64'h1);
      send_sheet(sheet_c);
      check_eq("c_answers", 64'(bus.student_answers), 64'h8421842184);
      check_eq("c_valid", 64'(bus.sheet_valid), 64'h1);
      bus.sheet_ack = 1'b1;
      tick();
      bus.sheet_ack = 1'b0;

      // Gapped reads: one nibble per accepted cycle only
      start_sheet();
      for (int k = 0; k < 10; k++) begin
         send(sheet_d[(9 - k) * 4 +: 4]);
         tick();
      end
      check_eq("d_answers", 64'(bus.student_answers), 64'h1248124812);
      check_eq("d_valid", 64'(bus.sheet_valid), 64'h1);
      bus.sheet_ack = 1'b1;
      tick();
      bus.sheet_ack = 1'b0;

      // Reset mid-load: asynchronous clear, no sheet_valid afterwards
      start_sheet();
      for (int k = 0; k < 7; k++) send(sheet_a[(9 - k) * 4 +: 4]);
      check_eq("pre_rst_idx", 64'(bus.q_index), 64'h7);
      #2;
      reset_n = 1'b0;
      #1;
      check_eq("arst_answers", 64'(bus.student_answers), 64'h0);
      check_eq("arst_idx", 64'(bus.q_index), 64'h0);
      check_eq("arst_ready", 64'(bus.bubble_ready), 64'h0);
      tick();
      reset_n = 1'b1;
      bus.bubble_valid = 1'b1;
      bus.bubble_data  = 4'h1;
      valid_seen = 0;
      for (int k = 0; k < 12; k++) begin
         tick();
         if (bus.sheet_valid) valid_seen++;
      end
      bus.bubble_valid = 1'b0;
      check_eq("post_rst_valid", 64'(valid_seen), 64'h0);
      check_eq("post_rst_idx", 64'(bus.q_index), 64'h0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
